// File: rtl/dpr_pkg.sv
// Shared definitions for the dual-port-RAM stream reader.
package dpr_pkg;

    // Default geometry: 4096 words of 8 bits.
    localparam int DPR_ADDR_W = 12;
    localparam int DPR_DATA_W = 8;

    // Transfer sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dpr_state_t;

endpackage

// File: rtl/dpr_skid_fifo.sv
// Two-entry output buffer holding {last, data} beats between the RAM read
// port and the stream sink. The head is held stable until it is popped.
module dpr_skid_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   cnt;
    logic         do_pop;
    logic         do_wr;

    // Pop only a present entry; a write into a full buffer is accepted only
    // when the head leaves in the same cycle, so nothing is ever overwritten.
    always_comb begin
        do_pop = pop && (cnt != 2'd0);
        do_wr  = wr_en && ((cnt != 2'd2) || do_pop);
    end

    // Storage, pointers and occupancy; everything clears on reset so the
    // head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wr_data;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            case ({do_wr, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign valid = (cnt != 2'd0);
    assign count = cnt;

endmodule

// File: rtl/dpr_stream_reader.sv
// Reads a block of consecutive RAM words and presents them as a
// valid/ready stream with a last marker. Reads are throttled so that the
// words already buffered plus the one in flight never exceed the two-entry
// output buffer, which still allows one beat per clock with a ready sink.
module dpr_stream_reader
    import dpr_pkg::*;
#(
    parameter int ADDR_W = DPR_ADDR_W,
    parameter int DATA_W = DPR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    dpr_state_t        state_q;
    dpr_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued_q;
    logic              inflight_p1;
    logic              inflight_last_p1;
    logic              done_q;
    logic              done_d;

    logic [DATA_W:0]   fifo_head;
    logic              fifo_valid;
    logic [1:0]        fifo_count;
    logic              pop;
    logic [2:0]        occ;
    logic              room;
    logic              more;
    logic              last_issue;
    logic              accept;

    // Buffer occupancy as it will stand after this cycle's pop and the
    // in-flight word landing; a new read is allowed only if that leaves a slot.
    always_comb begin
        pop    = fifo_valid && m_ready;
        occ    = {1'b0, fifo_count} + {2'b00, inflight_p1} - {2'b00, pop};
        room   = (occ <= 3'd1);
        more   = (issued_q < len_q);
        accept = (state_q == IDLE) && start && (len != '0);
    end

    // Next-state, read issue and completion pulse.
    always_comb begin
        state_d    = state_q;
        rd_en      = 1'b0;
        last_issue = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (more && room) begin
                    rd_en = 1'b1;
                    if (issued_q == (len_q - (ADDR_W + 1)'(1))) begin
                        last_issue = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && fifo_head[DATA_W]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Transfer parameters, read address and issue count; start is only
    // honoured from IDLE so a busy transfer keeps its parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            rd_addr_q <= '0;
            len_q     <= '0;
            issued_q  <= '0;
        end else if (accept) begin
            addr_q   <= base_addr;
            len_q    <= len;
            issued_q <= '0;
        end else if (rd_en) begin
            addr_q    <= addr_q + ADDR_W'(1);
            rd_addr_q <= addr_q;
            issued_q  <= issued_q + (ADDR_W + 1)'(1);
        end
    end

    // Track the read whose data arrives next cycle and whether it is the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_p1      <= 1'b0;
            inflight_last_p1 <= 1'b0;
        end else begin
            inflight_p1      <= rd_en;
            inflight_last_p1 <= last_issue;
        end
    end

    dpr_skid_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_p1),
        .wr_data ({inflight_last_p1, ram_rdata}),
        .pop     (pop),
        .head    (fifo_head),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign rd_addr = rd_en ? addr_q : rd_addr_q;
    assign m_valid = fifo_valid;
    assign m_data  = fifo_head[DATA_W-1:0];
    assign m_last  = fifo_valid && fifo_head[DATA_W];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: doc/dpr_stream_reader.md
DPR_STREAM_READER -- requirements
Module: dpr_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM address width (4096 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: port clk  input  1  rising-edge clock; port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  ADDR_W  first word address, latched on an accepted start.
REQ-006 SHALL have port len  input  ADDR_W+1  word count 0..4096, latched on an accepted start.
REQ-007 SHALL have port rd_addr  output  ADDR_W  read address to the RAM read port.
REQ-008 SHALL have port rd_en  output  1  high in each cycle a read is issued.
REQ-009 SHALL have port ram_rdata  input  DATA_W  RAM read data, valid exactly 1 clk after rd_addr/rd_en are sampled.
REQ-010 SHALL have port m_valid  output  1  stream beat valid.
REQ-011 SHALL have port m_data  output  DATA_W  stream beat data.
REQ-012 SHALL have port m_last  output  1  marks the final beat of a transfer.
REQ-013 SHALL have port m_ready  input  1  sink accepts the beat when m_valid&&m_ready.
REQ-014 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 IDLE: start with len>0 SHALL latch base_addr/len and go to RUN; start with len==0 SHALL pulse done next cycle and remain in IDLE.
REQ-018 RUN: a read SHALL issue (rd_en=1, rd_addr=current address) when issued<len and (fifo_count + inflight − pop) ≤ 1, where pop = m_valid&&m_ready.
REQ-019 The read address SHALL increment by 1 per issued read, modulo 2^ADDR_W (4095 wraps to 0).
REQ-020 ram_rdata SHALL be written into a 2-entry output FIFO in the cycle after its read issued; the FIFO SHALL never overflow.
REQ-021 m_data/m_valid SHALL come from the FIFO head; data SHALL be held stable while m_valid&&!m_ready.
REQ-022 Sustained throughput SHALL be 1 beat/clk with m_ready held high; first m_valid SHALL rise 2 clks after the accepted start edge.
REQ-023 The FSM SHALL go RUN→DRAIN when the len-th read issues, and DRAIN→IDLE when the beat with m_last is accepted, with done pulsing in the following cycle.
REQ-024 m_last SHALL be high only with the len-th beat of the transfer.
REQ-025 start while busy SHALL be ignored and SHALL leave latched parameters unaffected.
REQ-026 rd_en SHALL be 0 in IDLE and DRAIN; rd_addr SHALL hold its last value when not reading.

Reset
REQ-027 rst SHALL be synchronous and dominate all other inputs.
REQ-028 On rst the block SHALL enter IDLE and drive m_valid=0, m_last=0, rd_en=0, busy=0, done=0, rd_addr=0, m_data=0.
REQ-029 On rst the FIFO, in-flight flag, address and counters SHALL be cleared; reset mid-transfer SHALL abort with no done pulse, and a read in flight SHALL be discarded.

Structure
REQ-030 Shared package dpr_pkg SHALL hold ADDR_W/DATA_W defaults and the state enum (IDLE, RUN, DRAIN).
REQ-031 The output buffer SHALL be a sub-module dpr_skid_fifo (2 entries, DATA_W+1 wide: data plus last).

Verification
REQ-032 Preload RAM 0:aa, 1:bb, 2:cc; start base=0 len=3 with m_ready=1 -> m_data aa,bb,cc on 3 consecutive clks, first beat 2 clks after start, m_last with cc, done 1 clk after.
REQ-033 Same transfer with m_ready toggling 1,0,0,1,0,1... -> same order, no loss or duplication, m_data stable while stalled, at most 2 outstanding reads.
REQ-034 base=4095 len=2, RAM[4095]=11, RAM[0]=22 -> rd_addr 4095 then 0, beats 11,22.
REQ-035 start len=0 -> done pulse next clk, busy stays 0, no rd_en, no m_valid.
REQ-036 rst asserted mid-transfer after 1 beat -> next clk: all outputs at reset values, no done; a new start base=1 len=1 -> single beat bb with m_last.
REQ-037 start pulsed during RUN with different base/len -> ignored, original transfer completes unchanged.
